// File: rtl/pong_game_engine.sv
// rtl/pong_game_engine.sv - frame-rate Pong game-state engine
// Owns paddles, ball motion, scores and serve/point/game-over sequencing; advances once per frame_tick.
module pong_game_engine #(
  parameter int H_PERIOD     = 640,
  parameter int V_PERIOD     = 480,
  parameter int BORDER       = 10,
  parameter int PADDLE_LEN   = 50,
  parameter int PADDLE_THICK = 10,
  parameter int PADDLE_X_OFS = 40,
  parameter int BALL_SIDE    = 10,
  parameter int PADDLE_STEP  = 4,
  parameter int BALL_SPEED   = 2,
  parameter int PAUSE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_p1_up,
  input  logic        btn_p1_down,
  input  logic        btn_p2_up,
  input  logic        btn_p2_down,
  input  logic        btn_serve,
  output logic [11:0] paddle_1,
  output logic [11:0] paddle_2,
  output logic [11:0] ball_x,
  output logic [11:0] ball_y,
  output logic [3:0]  score_1,
  output logic [3:0]  score_2,
  output logic [1:0]  state,
  output logic        game_over
);

  localparam int W  = 13;
  localparam int CW = $clog2(PAUSE_FRAMES + 1);

  localparam logic [W-1:0] STEP_W      = W'(PADDLE_STEP);
  localparam logic [W-1:0] SPEED_W     = W'(BALL_SPEED);
  localparam logic [W-1:0] SIDE_W      = W'(BALL_SIDE);
  localparam logic [W-1:0] LEN_W       = W'(PADDLE_LEN);
  localparam logic [W-1:0] BORDER_W    = W'(BORDER);
  localparam logic [W-1:0] PADDLE_HOME = W'((V_PERIOD - PADDLE_LEN) / 2);
  localparam logic [W-1:0] PADDLE_MAX  = W'(V_PERIOD - BORDER - PADDLE_LEN);
  localparam logic [W-1:0] PADDLE_LIFT = W'(BORDER + PADDLE_STEP);
  localparam logic [W-1:0] BALL_X0     = W'((H_PERIOD - BALL_SIDE) / 2);
  localparam logic [W-1:0] BALL_Y0     = W'((V_PERIOD - BALL_SIDE) / 2);
  localparam logic [W-1:0] BALL_Y_MAX  = W'(V_PERIOD - BORDER - BALL_SIDE);
  localparam logic [W-1:0] EDGE_LO     = W'(BORDER + BALL_SPEED);
  localparam logic [W-1:0] FACE_1      = W'(PADDLE_X_OFS + PADDLE_THICK);
  localparam logic [W-1:0] STOP_2      = W'(H_PERIOD - PADDLE_X_OFS - PADDLE_THICK - BALL_SIDE - 1);
  localparam logic [W-1:0] X_MISS_R    = W'(H_PERIOD - BORDER - BALL_SIDE);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PLAY      = 2'd1,
    S_POINT     = 2'd2,
    S_GAME_OVER = 2'd3
  } state_t;

  state_t        state_q;
  logic          dx_right;
  logic          dy_down;
  logic [CW-1:0] pause_cnt;

  // Lower limit is checked before subtracting so a paddle never wraps past the border.
  function automatic logic [11:0] paddle_next(input logic [11:0] p, input logic up, input logic dn);
    logic [W-1:0] pw;
    pw = {1'b0, p};
    if (up && !dn)
      paddle_next = (pw >= PADDLE_LIFT) ? 12'(pw - STEP_W) : 12'(BORDER_W);
    else if (dn && !up)
      paddle_next = (pw + STEP_W <= PADDLE_MAX) ? 12'(pw + STEP_W) : 12'(PADDLE_MAX);
    else
      paddle_next = p;
  endfunction

  function automatic logic overlaps(input logic [W-1:0] by, input logic [W-1:0] py);
    overlaps = (by + SIDE_W > py) && (by < py + LEN_W);
  endfunction

  logic [W-1:0] bx, by, bx_fwd;
  logic         miss_l, miss_r, hit_1, hit_2, hit_top, hit_bottom;
  logic [3:0]   score_1_inc, score_2_inc;

  always_comb begin
    bx          = {1'b0, ball_x};
    by          = {1'b0, ball_y};
    bx_fwd      = dx_right ? bx + SPEED_W : bx - SPEED_W;
    miss_l      = !dx_right && (bx <= EDGE_LO);
    miss_r      = dx_right && (bx_fwd >= X_MISS_R);
    hit_1       = !dx_right && (bx >= FACE_1) && (bx_fwd <= FACE_1) && overlaps(by, {1'b0, paddle_1});
    hit_2       = dx_right && (bx <= STOP_2) && (bx_fwd >= STOP_2) && overlaps(by, {1'b0, paddle_2});
    hit_bottom  = dy_down && (by + SPEED_W >= BALL_Y_MAX);
    hit_top     = !dy_down && (by <= EDGE_LO);
    score_1_inc = score_1 + 4'd1;
    score_2_inc = score_2 + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      paddle_1  <= 12'(PADDLE_HOME);
      paddle_2  <= 12'(PADDLE_HOME);
      ball_x    <= 12'(BALL_X0);
      ball_y    <= 12'(BALL_Y0);
      score_1   <= '0;
      score_2   <= '0;
      state_q   <= S_IDLE;
      game_over <= 1'b0;
      dx_right  <= 1'b1;
      dy_down   <= 1'b1;
      pause_cnt <= '0;
    end else begin
      if (frame_tick) begin
        paddle_1 <= paddle_next(paddle_1, btn_p1_up, btn_p1_down);
        paddle_2 <= paddle_next(paddle_2, btn_p2_up, btn_p2_down);
      end
      case (state_q)
        S_IDLE: begin
          if (btn_serve) state_q <= S_PLAY;
        end
        S_PLAY: begin
          if (frame_tick) begin
            // A miss outranks any wall bounce on the same frame; direction is kept for the next serve.
            if (miss_l || miss_r) begin
              ball_x    <= 12'(BALL_X0);
              ball_y    <= 12'(BALL_Y0);
              pause_cnt <= '0;
              if (miss_r) begin
                score_1 <= score_1_inc;
                if (score_1_inc == 4'(WIN_SCORE)) begin
                  state_q   <= S_GAME_OVER;
                  game_over <= 1'b1;
                end else begin
                  state_q <= S_POINT;
                end
              end else begin
                score_2 <= score_2_inc;
                if (score_2_inc == 4'(WIN_SCORE)) begin
                  state_q   <= S_GAME_OVER;
                  game_over <= 1'b1;
                end else begin
                  state_q <= S_POINT;
                end
              end
            end else begin
              if (hit_1) begin
                ball_x   <= 12'(FACE_1);
                dx_right <= 1'b1;
              end else if (hit_2) begin
                ball_x   <= 12'(STOP_2);
                dx_right <= 1'b0;
              end else begin
                ball_x <= 12'(bx_fwd);
              end
              if (hit_bottom) begin
                ball_y  <= 12'(BALL_Y_MAX);
                dy_down <= 1'b0;
              end else if (hit_top) begin
                ball_y  <= 12'(BORDER_W);
                dy_down <= 1'b1;
              end else begin
                ball_y <= dy_down ? 12'(by + SPEED_W) : 12'(by - SPEED_W);
              end
            end
          end
        end
        S_POINT: begin
          if (frame_tick) begin
            pause_cnt <= pause_cnt + CW'(1);
            if (pause_cnt == CW'(PAUSE_FRAMES - 1)) state_q <= S_IDLE;
          end
        end
        S_GAME_OVER: begin
          if (btn_serve) begin
            score_1   <= '0;
            score_2   <= '0;
            state_q   <= S_IDLE;
            game_over <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pong_game_engine.sv
// tb/tb_pong_game_engine.sv - self-checking bench for pong_game_engine
// Frame-level reference model compared every cycle, plus directed scenarios with literal expectations.
module tb_pong_game_engine;

  localparam int H      = 640;
  localparam int V      = 480;
  localparam int BORDER = 10;
  localparam int PLEN   = 50;
  localparam int PTHICK = 10;
  localparam int POFS   = 40;
  localparam int SIDE   = 10;
  localparam int STEP   = 4;
  localparam int SPEED  = 2;
  localparam int PAUSE  = 60;
  localparam int WIN    = 2;

  localparam int CX      = (H - SIDE) / 2;
  localparam int CY      = (V - SIDE) / 2;
  localparam int HOME    = (V - PLEN) / 2;
  localparam int P1_FACE = POFS + PTHICK;
  localparam int P2_STOP = H - POFS - PTHICK - SIDE - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic btn_p1_up = 1'b0, btn_p1_down = 1'b0, btn_p2_up = 1'b0, btn_p2_down = 1'b0;
  logic btn_serve = 1'b0;
  logic [11:0] paddle_1, paddle_2, ball_x, ball_y;
  logic [3:0]  score_1, score_2;
  logic [1:0]  state;
  logic        game_over;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  pong_game_engine #(.WIN_SCORE(WIN)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_p1_up(btn_p1_up), .btn_p1_down(btn_p1_down),
    .btn_p2_up(btn_p2_up), .btn_p2_down(btn_p2_down),
    .btn_serve(btn_serve),
    .paddle_1(paddle_1), .paddle_2(paddle_2), .ball_x(ball_x), .ball_y(ball_y),
    .score_1(score_1), .score_2(score_2), .state(state), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int p1; int p2; int bx; int by; int s1; int s2; int st; int cnt;
    bit dxr; bit dyd;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t reset_model();
    mstate_t r;
    r.p1 = HOME; r.p2 = HOME; r.bx = CX; r.by = CY;
    r.s1 = 0; r.s2 = 0; r.st = 0; r.cnt = 0; r.dxr = 1'b1; r.dyd = 1'b1;
    return r;
  endfunction

  function automatic int pad_move(int p, bit up, bit dn);
    if (up && !dn) return (p - STEP < BORDER) ? BORDER : p - STEP;
    if (dn && !up) return (p + STEP > V - BORDER - PLEN) ? V - BORDER - PLEN : p + STEP;
    return p;
  endfunction

  function automatic bit covers(int y, int p);
    return (y + SIDE > p) && (y < p + PLEN);
  endfunction

  function automatic mstate_t model_next(mstate_t c, bit r, bit t, bit p1u, bit p1d,
                                         bit p2u, bit p2d, bit sv);
    mstate_t n;
    int nx;
    if (r) return reset_model();
    n = c;
    if (t) begin
      n.p1 = pad_move(c.p1, p1u, p1d);
      n.p2 = pad_move(c.p2, p2u, p2d);
    end
    case (c.st)
      0: if (sv) n.st = 1;
      1: if (t) begin
        nx = c.dxr ? c.bx + SPEED : c.bx - SPEED;
        if ((c.dxr && nx + SIDE >= H - BORDER) || (!c.dxr && c.bx <= BORDER + SPEED)) begin
          if (c.dxr) n.s1 = c.s1 + 1; else n.s2 = c.s2 + 1;
          n.bx = CX; n.by = CY; n.cnt = 0;
          n.st = (n.s1 == WIN || n.s2 == WIN) ? 3 : 2;
        end else begin
          n.bx = nx;
          if (!c.dxr && c.bx >= P1_FACE && nx <= P1_FACE && covers(c.by, c.p1)) begin
            n.bx = P1_FACE; n.dxr = 1'b1;
          end
          if (c.dxr && c.bx <= P2_STOP && nx >= P2_STOP && covers(c.by, c.p2)) begin
            n.bx = P2_STOP; n.dxr = 1'b0;
          end
          if (c.dyd) begin
            if (c.by + SPEED >= V - BORDER - SIDE) begin n.by = V - BORDER - SIDE; n.dyd = 1'b0; end
            else n.by = c.by + SPEED;
          end else begin
            if (c.by <= BORDER + SPEED) begin n.by = BORDER; n.dyd = 1'b1; end
            else n.by = c.by - SPEED;
          end
        end
      end
      2: if (t) begin
        n.cnt = c.cnt + 1;
        if (n.cnt == PAUSE) n.st = 0;
      end
      default: if (sv) begin n.s1 = 0; n.s2 = 0; n.st = 0; end
    endcase
    return n;
  endfunction

  always @(posedge clk)
    m <= model_next(m, rst, frame_tick, btn_p1_up, btn_p1_down, btn_p2_up, btn_p2_down, btn_serve);

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (int'(paddle_1) != m.p1 || int'(paddle_2) != m.p2 || int'(ball_x) != m.bx ||
          int'(ball_y) != m.by || int'(score_1) != m.s1 || int'(score_2) != m.s2 ||
          int'(state) != m.st || game_over != (m.st == 3)) begin
        errors++;
        if (errors <= 20)
          $display("FAIL model_cmp t=%0t got p=%0d/%0d b=(%0d,%0d) s=%0d/%0d st=%0d go=%0d want p=%0d/%0d b=(%0d,%0d) s=%0d/%0d st=%0d",
                   $time, paddle_1, paddle_2, ball_x, ball_y, score_1, score_2, state, game_over,
                   m.p1, m.p2, m.bx, m.by, m.s1, m.s2, m.st);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic pulse_serve();
    @(negedge clk); btn_serve = 1'b1;
    @(negedge clk); btn_serve = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_p1"}, paddle_1, 215);
    check({tag, "_p2"}, paddle_2, 215);
    check({tag, "_bx"}, ball_x, 315);
    check({tag, "_by"}, ball_y, 235);
    check({tag, "_s1"}, score_1, 0);
    check({tag, "_s2"}, score_2, 0);
    check({tag, "_state"}, state, 0);
    check({tag, "_go"}, game_over, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check_reset_values("reset");

    // paddle travel and clamps
    btn_p1_up = 1'b1; btn_p2_down = 1'b1;
    ticks(1);  check("p1_t1", paddle_1, 211); check("p2_t1", paddle_2, 219);
    ticks(50); check("p1_t51", paddle_1, 11); check("p2_t51", paddle_2, 419);
    ticks(1);  check("p1_t52", paddle_1, 10); check("p2_t52", paddle_2, 420);
    ticks(8);  check("p1_t60", paddle_1, 10); check("p2_t60", paddle_2, 420);
    check("idle_bx", ball_x, 315);
    btn_p1_down = 1'b1; btn_p2_up = 1'b1;
    ticks(3);  check("p1_both", paddle_1, 10); check("p2_both", paddle_2, 420);
    btn_p1_up = 1'b0; btn_p1_down = 1'b0; btn_p2_up = 1'b0; btn_p2_down = 1'b0;

    // rally missed by paddle 2
    reset_dut();
    pulse_serve();
    check("serve_state", state, 1);
    ticks(113); check("wall_by113", ball_y, 460); check("wall_bx113", ball_x, 541);
    ticks(1);   check("wall_by114", ball_y, 458);
    ticks(18);  check("miss_bx132", ball_x, 579); check("miss_by132", ball_y, 422);
    check("miss_state132", state, 1);
    ticks(21);  check("pt_s1", score_1, 1); check("pt_state", state, 2);
    check("pt_bx", ball_x, 315); check("pt_by", ball_y, 235);

    // serve ignored during the pause, exact exit timing
    @(negedge clk); btn_serve = 1'b1;
    ticks(5);
    btn_serve = 1'b0;
    check("pause_serve_ign", state, 2);
    ticks(54); check("pause_59", state, 2);
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    check("pause_60_idle", state, 0);
    pulse_serve();
    ticks(1); check("resume_bx", ball_x, 317); check("resume_by", ball_y, 233);

    // second P1 point reaches WIN
    ticks(152);
    check("go_state", state, 3); check("go_flag", game_over, 1); check("go_s1", score_1, 2);
    ticks(3);  check("go_frozen", score_1, 2);
    pulse_serve();
    check("go_serve_state", state, 0); check("go_serve_s1", score_1, 0);
    check("go_serve_flag", game_over, 0);

    // serve on a tick, then paddle 2 returns the ball
    reset_dut();
    @(negedge clk); btn_serve = 1'b1; frame_tick = 1'b1;
    @(negedge clk); btn_serve = 1'b0; frame_tick = 1'b0;
    check("cotick_state", state, 1); check("cotick_bx", ball_x, 315); check("cotick_by", ball_y, 235);
    btn_p2_down = 1'b1;
    ticks(40);
    btn_p2_down = 1'b0;
    check("hit_p2", paddle_2, 375);
    ticks(92);  check("hit_bx132", ball_x, 579); check("hit_state", state, 1);
    ticks(1);   check("hit_bx133", ball_x, 577); check("hit_s1", score_1, 0); check("hit_s2", score_2, 0);
    ticks(290); check("p2pt_s2", score_2, 1); check("p2pt_s1", score_1, 0); check("p2pt_state", state, 2);

    // reset mid-PLAY
    ticks(60);
    pulse_serve();
    btn_p1_up = 1'b1;
    ticks(20);
    check("midplay_state", state, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    btn_p1_up = 1'b0;
    check_reset_values("midrst");
    ticks(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/pong_game_engine.md
# pong_game_engine

Frame-rate game-state engine for the Pong display path: owns paddle positions, ball position and direction, scores and the serve/point/game-over sequencing. Advances once per video frame on a `frame_tick` pulse from the VGA timing stage. Drives the paddle and ball coordinates consumed by the graphics generator, in active-area pixel coordinates (origin at top-left visible pixel).

## Interface
- `H_PERIOD`, 640, visible width (px)
- `V_PERIOD`, 480, visible height (px)
- `BORDER`, 10, border thickness (px)
- `PADDLE_LEN`, 50, paddle height (px)
- `PADDLE_THICK`, 10, paddle width (px)
- `PADDLE_X_OFS`, 40, paddle inset from left/right edge (px)
- `BALL_SIDE`, 10, ball edge length (px)
- `PADDLE_STEP`, 4, paddle move per frame (px)
- `BALL_SPEED`, 2, ball move per frame per axis (px)
- `PAUSE_FRAMES`, 60, frames held in POINT
- `WIN_SCORE`, 9, score that ends the game

Ports:
- `clk` in 1: system/pixel clock; single clock domain
- `rst` in 1: synchronous, active-high reset
- `frame_tick` in 1: one-cycle pulse per frame, issued during vertical blanking
- `btn_p1_up`, `btn_p1_down`, `btn_p2_up`, `btn_p2_down` in 1 each: debounced, synchronous levels
- `btn_serve` in 1: debounced, synchronous level
- `paddle_1`, `paddle_2` out 12: paddle top y
- `ball_x`, `ball_y` out 12: ball top-left
- `score_1`, `score_2` out 4
- `state` out 2: IDLE=0, PLAY=1, POINT=2, GAME_OVER=3
- `game_over` out 1: high iff `state`==GAME_OVER

## Operation
- Reset values: paddles=215 ((V_PERIOD-PADDLE_LEN)/2); ball_x=315, ball_y=235 (centre); scores=0; `state`=IDLE; dx=right, dy=down; pause counter=0.
- Paddles move on `frame_tick` in every state. Up only: p=max(p-STEP, BORDER). Down only: p=min(p+STEP, V_PERIOD-BORDER-PADDLE_LEN)=420. Both or neither: hold.
- IDLE: ball held at centre. `btn_serve`=1 on any cycle -> PLAY.
- PLAY, per `frame_tick`: x and y axes update independently.
  - Y: down and ball_y+SPEED >= 460 -> ball_y=460, dy=up. Up and ball_y <= BORDER+SPEED -> ball_y=10, dy=down. Otherwise ball_y += or -= SPEED.
  - X, paddle 1 face at x=50: moving left, ball_x >= 50 and next_x <= 50 -> check overlap (ball_y+BALL_SIDE > paddle_1 && ball_y < paddle_1+PADDLE_LEN). Hit: ball_x=50, dx=right.
  - X, paddle 2 face at x=589 (ball stop at 579): moving right, ball_x <= 579 and next_x >= 579 -> same overlap test vs `paddle_2`. Hit: ball_x=579, dx=left.
  - Miss: moving left and ball_x <= BORDER+SPEED -> point to P2. Moving right and next_x+BALL_SIDE >= H_PERIOD-BORDER (next_x >= 620) -> point to P1.
- Point: scorer's score +1; ball recentred; dx, dy retained; pause counter=0. If new score == WIN_SCORE -> GAME_OVER, else POINT.
- POINT: ball at centre. Counter +1 per `frame_tick`; at PAUSE_FRAMES -> IDLE. `btn_serve` ignored.
- GAME_OVER: ball at centre, scores frozen. `btn_serve` -> scores=0, IDLE.
- Arithmetic: 13-bit internal. Compare before subtracting; no coordinate ever wraps below 0.

## Timing
- All outputs registered. Updates from a `frame_tick` in cycle N are visible at N+1.
- Outputs are constant between ticks, so they are stable across the active video area.
- IDLE->PLAY takes effect the cycle after `btn_serve`. If `frame_tick` and `btn_serve` coincide in IDLE: enter PLAY, ball does not move on that tick.
- Miss and wall bounce on the same tick: the point wins.
- Paddle hit and wall bounce on the same tick: both apply.
- `rst` overrides everything on any cycle, including mid-PLAY and mid-POINT.

## Test plan
- Reset -> paddle_1=paddle_2=215, ball=(315,235), scores 0, `state`=0, `game_over`=0.
- Hold `btn_p1_up` 60 ticks -> paddle_1 = 211, 207, … 11, then 10 from tick 52 on. Hold `btn_p2_down` -> paddle_2 reaches 419 at tick 51, then 420 held. Both P1 buttons held -> no change.
- Serve, no buttons -> ball_y=461-clamped to 460 at tick 113, then 458 at tick 114. Paddle 2 missed at tick 132 (ball_y=422). At tick 153 -> score_1=1, `state`=2, ball=(315,235).
- Serve, hold `btn_p2_down` for ticks 1-40 (paddle_2=375) -> tick 132: ball_x=579, dx=left. Tick 133: ball_x=577. Scores unchanged.
- After a point: `btn_serve` pulses during POINT are ignored. `state`=IDLE exactly one cycle after the 60th tick. Serve -> ball resumes with retained dx.
- WIN_SCORE=2, two P1 points -> `state`=3, `game_over`=1. `rst` mid-PLAY returns all reset values the next cycle. `btn_serve` in GAME_OVER -> scores 0, IDLE.
